// File: rtl/axis_packer_pkg.sv
// Shared types and sizing helpers for the burst packer.
package axis_packer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_SEND = 4'b0100,
    ST_DONE = 4'b1000
  } rd_state_e;

  function automatic int beats_per_rec(input int rec_bits, input int axis_w);
    return (rec_bits + axis_w - 1) / axis_w;
  endfunction

  // Valid bytes on the final beat of a record; a full beat when it divides evenly.
  function automatic int last_beat_bytes(input int rec_bits, input int axis_w);
    int rem;
    rem = rec_bits % axis_w;
    return (rem == 0) ? axis_w / 8 : rem / 8;
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axis_packer_ring.sv
// Ring of NUM_BUFS burst buffers: record storage, write/read pointers,
// per-buffer record counts, occupancy level and upstream ready.
module axis_packer_ring
  import axis_packer_pkg::*;
#(
  parameter int DATA_WIDTH     = 16000,
  parameter int PKTS_PER_BURST = 8,
  parameter int NUM_BUFS       = 2,
  localparam int BW = ptr_w(NUM_BUFS),
  localparam int IW = ptr_w(PKTS_PER_BURST),
  localparam int CW = cnt_w(PKTS_PER_BURST),
  localparam int LW = $clog2(NUM_BUFS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  input  logic [IW-1:0]         rd_rec,
  input  logic                  rel_buf,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         rd_cnt,
  output logic [LW-1:0]         buf_level
);

  logic [DATA_WIDTH-1:0] mem [NUM_BUFS][PKTS_PER_BURST];
  logic [CW-1:0]         cnt [NUM_BUFS];
  logic [BW-1:0]         wr_buf;
  logic [BW-1:0]         rd_buf;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         fill;
  logic                  accept;
  logic                  close;

  // While any buffer is free, the write buffer is free too, so a full ring
  // always has wr_cnt==0 and cannot be closed by a stray flush.
  assign s_ready = (buf_level < LW'(NUM_BUFS));
  assign accept  = s_valid & s_ready;
  assign fill    = wr_cnt + CW'(accept);
  assign close   = (accept && (wr_cnt == CW'(PKTS_PER_BURST - 1))) ||
                   (flush && (fill != '0));

  assign rd_data = mem[rd_buf][rd_rec];
  assign rd_cnt  = cnt[rd_buf];

  // Record storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem[wr_buf][wr_cnt[IW-1:0]] <= s_data;
  end

  // Pointer, count and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_buf    <= '0;
      rd_buf    <= '0;
      wr_cnt    <= '0;
      buf_level <= '0;
      for (int i = 0; i < NUM_BUFS; i++) cnt[i] <= '0;
    end else begin
      if (close) begin
        cnt[wr_buf] <= fill;
        wr_buf      <= wr_buf + 1'b1;
        wr_cnt      <= '0;
      end else if (accept) begin
        wr_cnt <= fill;
      end
      if (rel_buf) rd_buf <= rd_buf + 1'b1;
      case ({close, rel_buf})
        2'b10:   buf_level <= buf_level + 1'b1;
        2'b01:   buf_level <= buf_level - 1'b1;
        default: buf_level <= buf_level;
      endcase
    end
  end

endmodule

// File: rtl/axis_burst_packer.sv
// Packs sequence-tagged records from a ring of burst buffers into AXI-Stream
// bursts for the XDMA C2H channel. Optional macro AXIS_PACKER_TKEEP_TRIM_EN
// trims tkeep on the tlast beat to the bytes actually carrying record data.
module axis_burst_packer
  import axis_packer_pkg::*;
#(
  parameter int DATA_WIDTH      = 16000,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int PKTS_PER_BURST  = 8,
  parameter int NUM_BUFS        = 2,
  parameter int SEQ_WIDTH       = 8
) (
  input  logic                           m_axis_c2h_aclk,
  input  logic                           m_axis_c2h_areset,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           flush,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_c2h_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_c2h_tkeep,
  output logic                           m_axis_c2h_tlast,
  output logic                           m_axis_c2h_tvalid,
  input  logic                           m_axis_c2h_tready,
  output logic [$clog2(NUM_BUFS+1)-1:0]  buf_level,
  output logic [15:0]                    burst_cnt,
  output logic [3:0]                     sstate
);

  localparam int RECORD_BITS = DATA_WIDTH + SEQ_WIDTH;
  localparam int BPR         = beats_per_rec(RECORD_BITS, AXIS_DATA_WIDTH);
  localparam int SR_W        = BPR * AXIS_DATA_WIDTH;
  localparam int KEEP_W      = AXIS_DATA_WIDTH / 8;
  localparam int IW          = ptr_w(PKTS_PER_BURST);
  localparam int CW          = cnt_w(PKTS_PER_BURST);
  localparam int BEAT_W      = ptr_w(BPR);

  rd_state_e             state, state_nxt;
  logic [SR_W-1:0]       sr;
  logic [SR_W-1:0]       rec_word;
  logic [SEQ_WIDTH-1:0]  seq;
  logic [IW-1:0]         rec_idx;
  logic [IW-1:0]         rec_nxt;
  logic [IW-1:0]         rd_rec;
  logic [BEAT_W-1:0]     beat_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CW-1:0]         rd_cnt;
  logic                  rel_buf;
  logic                  hs;
  logic                  last_beat;
  logic                  last_rec;

  axis_packer_ring #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PKTS_PER_BURST (PKTS_PER_BURST),
    .NUM_BUFS       (NUM_BUFS)
  ) u_ring (
    .clk       (m_axis_c2h_aclk),
    .rst       (m_axis_c2h_areset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .flush     (flush),
    .rd_rec    (rd_rec),
    .rel_buf   (rel_buf),
    .rd_data   (rd_data),
    .rd_cnt    (rd_cnt),
    .buf_level (buf_level)
  );

  assign hs        = m_axis_c2h_tvalid & m_axis_c2h_tready;
  assign last_beat = (beat_idx == BEAT_W'(BPR - 1));
  assign last_rec  = (CW'(rec_idx) == rd_cnt - 1'b1);
  assign rec_nxt   = (rec_idx == IW'(PKTS_PER_BURST - 1)) ? '0 : rec_idx + 1'b1;
  // LOAD fetches record 0; during SEND the next record is pre-addressed so it
  // can be loaded on the final beat of the current one without a bubble.
  assign rd_rec    = (state == ST_SEND) ? rec_nxt : '0;

  // Frame the addressed record as {zero pad, payload, seq}.
  always_comb begin
    rec_word                    = '0;
    rec_word[RECORD_BITS-1:0]   = {rd_data, seq};
  end

  // Read FSM state register.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (m_axis_c2h_areset) state <= ST_IDLE;
    else                   state <= state_nxt;
  end

  // Read FSM next state and buffer release strobe.
  always_comb begin
    state_nxt = state;
    rel_buf   = 1'b0;
    case (state)
      ST_IDLE: if (buf_level != '0) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (hs && last_beat && last_rec) state_nxt = ST_DONE;
      ST_DONE: begin
        rel_buf   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, sequence counter, record/beat indices and burst counter.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (m_axis_c2h_areset) begin
      sr        <= '0;
      seq       <= '0;
      rec_idx   <= '0;
      beat_idx  <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          sr       <= rec_word;
          seq      <= seq + 1'b1;
          rec_idx  <= '0;
          beat_idx <= '0;
        end
        ST_SEND: begin
          if (hs) begin
            if (!last_beat) begin
              sr       <= sr >> AXIS_DATA_WIDTH;
              beat_idx <= beat_idx + 1'b1;
            end else if (!last_rec) begin
              sr       <= rec_word;
              seq      <= seq + 1'b1;
              rec_idx  <= rec_nxt;
              beat_idx <= '0;
            end
          end
        end
        ST_DONE: burst_cnt <= burst_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs come straight from registered state, so they only move on a
  // handshake or state change and stay stable through stalls.
  assign m_axis_c2h_tvalid = (state == ST_SEND);
  assign m_axis_c2h_tlast  = m_axis_c2h_tvalid && last_beat && last_rec;
  assign m_axis_c2h_tdata  = sr[AXIS_DATA_WIDTH-1:0];
  assign sstate            = state;

`ifdef AXIS_PACKER_TKEEP_TRIM_EN
  localparam int LAST_BYTES = last_beat_bytes(RECORD_BITS, AXIS_DATA_WIDTH);
  logic [KEEP_W-1:0] keep_last;

  // Byte mask covering only the record bytes of the final beat.
  always_comb begin
    keep_last = '0;
    for (int i = 0; i < KEEP_W; i++) keep_last[i] = (i < LAST_BYTES);
  end

  assign m_axis_c2h_tkeep = m_axis_c2h_tlast ? keep_last : {KEEP_W{1'b1}};
`else
  assign m_axis_c2h_tkeep = {KEEP_W{1'b1}};
`endif

endmodule

// File: tb/tb_axis_burst_packer.sv
// Scoreboard bench for axis_burst_packer (DATA 1000, SEQ 8, AXIS 512, 8 per burst, 4 buffers).
module tb_axis_burst_packer;

  localparam int DW = 1000;
  localparam int AW = 512;
  localparam int KW = AW / 8;
  localparam int PK = 8;
  localparam int NB = 4;
  localparam int SW = 8;

  typedef struct {
    logic [AW-1:0] d;
    logic          last;
    logic [KW-1:0] k;
  } beat_t;

  logic          clk = 0;
  logic          rst = 1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 0;
  logic          s_ready;
  logic          flush = 0;
  logic [AW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready = 0;
  logic [2:0]    buf_level;
  logic [15:0]   burst_cnt;
  logic [3:0]    sstate;

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 never, 3 manual

  beat_t         exp_q[$];
  logic [DW-1:0] wbuf[$];
  logic [SW-1:0] mseq = '0;
  int            mbursts = 0;

  axis_burst_packer #(
    .DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW), .PKTS_PER_BURST(PK),
    .NUM_BUFS(NB), .SEQ_WIDTH(SW)
  ) dut (
    .m_axis_c2h_aclk(clk), .m_axis_c2h_areset(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .flush(flush),
    .m_axis_c2h_tdata(tdata), .m_axis_c2h_tkeep(tkeep), .m_axis_c2h_tlast(tlast),
    .m_axis_c2h_tvalid(tvalid), .m_axis_c2h_tready(tready),
    .buf_level(buf_level), .burst_cnt(burst_cnt), .sstate(sstate)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mkdata(input int tag);
    logic [1023:0] t;
    for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom ^ tag;
    return t[DW-1:0];
  endfunction

  // Closed buffer -> expected beats, sequence numbers in close order.
  task automatic model_close();
    logic [1023:0] rec;
    beat_t b;
    logic [KW-1:0] klast;
`ifdef AXIS_PACKER_TKEEP_TRIM_EN
    klast = 64'h3FFF_FFFF_FFFF_FFFF;
`else
    klast = '1;
`endif
    for (int r = 0; r < wbuf.size(); r++) begin
      rec = '0;
      rec[DW+SW-1:0] = {wbuf[r], mseq};
      mseq = mseq + 1'b1;
      for (int k = 0; k < 2; k++) begin
        b.d    = rec[k*AW +: AW];
        b.last = (r == wbuf.size() - 1) && (k == 1);
        b.k    = b.last ? klast : '1;
        exp_q.push_back(b);
      end
    end
    wbuf.delete();
    mbursts++;
  endtask

  task automatic send_rec(input logic [DW-1:0] d, input bit f, input int budget);
    int n = 0;
    while (!s_ready && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (!s_ready) begin
      chk("send_timeout", 64'(n), 64'(budget + 1));
    end else begin
      s_data = d; s_valid = 1; flush = f;
      @(posedge clk); #1;
      s_valid = 0; flush = 0;
      wbuf.push_back(d);
      if (f || wbuf.size() == PK) model_close();
    end
  endtask

  task automatic do_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    if (wbuf.size() > 0) model_close();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || buf_level != 0 || sstate != 4'b0001) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_burst_cnt"}, 64'(burst_cnt), 64'(mbursts[15:0]));
    chk({name, "_buf_level"}, 64'(buf_level), 64'd0);
  endtask

  task automatic do_reset();
    tready = 0;
    rst = 1;
    exp_q.delete(); wbuf.delete(); mseq = '0; mbursts = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // tready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tready = 1;
        1: tready = 1'($urandom_range(0, 1));
        2: tready = 0;
        default: ;
      endcase
    end
  end

  // Output monitor: compares each handshaken beat and checks stall stability.
  initial begin
    beat_t e;
    bit hold_v = 0;
    logic [AW-1:0] hd;
    logic hl;
    logic [KW-1:0] hk;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          n_chk++;
          if (tvalid && tdata == hd && tlast == hl && tkeep == hk) n_pass++;
          else $display("FAIL stall_hold: got v=%0b l=%0b d=%0h expected v=1 l=%0b d=%0h",
                        tvalid, tlast, tdata[63:0], hl, hd[63:0]);
        end
        if (tvalid && tready) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL beat_extra: got d=%0h with empty scoreboard", tdata[63:0]);
          end else begin
            e = exp_q.pop_front();
            if (tdata == e.d && tlast == e.last && tkeep == e.k) n_pass++;
            else $display("FAIL beat: got d=%h l=%0b k=%h expected d=%h l=%0b k=%h",
                          tdata, tlast, tkeep, e.d, e.last, e.k);
          end
        end
        hold_v = tvalid && !tready;
        hd = tdata; hl = tlast; hk = tkeep;
      end
    end
  end

  initial begin
    bit ok;
    rdy_mode = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", tdata[63:0], 64'd0);
    chk("rst_buf_level", 64'(buf_level), 64'd0);
    chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
    chk("rst_sstate", 64'(sstate), 64'h1);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // 1: full burst, always ready
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) send_rec(mkdata(i), 0, 50);
    drain("t1", 200);

    // 2: full burst, random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_rec(mkdata(100 + i), 0, 50);
    drain("t2", 400);

    // 3: partial burst via flush, then flush on the same cycle as a record
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send_rec(mkdata(200 + i), 0, 50);
    do_flush();
    drain("t3", 200);
    do_flush();
    chk("t3_empty_flush_level", 64'(buf_level), 64'd0);
    send_rec(mkdata(210), 0, 50);
    send_rec(mkdata(211), 1, 50);
    drain("t3b", 200);

    // 4: ring fills with no downstream ready
    rdy_mode = 2;
    for (int i = 0; i < 32; i++) send_rec(mkdata(300 + i), 0, 50);
    repeat (4) @(posedge clk); #1;
    chk("t4_level_full", 64'(buf_level), 64'd4);
    s_data = mkdata(999); s_valid = 1;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (s_ready) ok = 0;
    end
    @(posedge clk); #1;
    s_valid = 0;
    chk("t4_s_ready_low", 64'(ok), 64'd1);
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) send_rec(mkdata(340 + i), 0, 200);
    drain("t4", 1000);

    // 5: 256 records wrap seq, empty flush adds no burst, then 4 more
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 256; i++) send_rec(mkdata(400 + i), 0, 100);
    do_flush();
    drain("t5", 1000);
    chk("t5_bursts_32", 64'(burst_cnt), 64'd32);
    for (int i = 0; i < 4; i++) send_rec(mkdata(700 + i), 0, 100);
    do_flush();
    drain("t5b", 200);

    // 6: reset during SEND at beat 5
    rdy_mode = 3;
    tready = 0;
    for (int i = 0; i < 8; i++) send_rec(mkdata(800 + i), 0, 50);
    begin
      int n = 0;
      while (!tvalid && n < 20) begin @(posedge clk); #1; n++; end
      chk("t6_tvalid_up", 64'(tvalid), 64'd1);
    end
    tready = 1;
    repeat (4) @(posedge clk);
    #1;
    tready = 0;
    rst = 1;
    exp_q.delete(); wbuf.delete(); mseq = '0; mbursts = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t6_tvalid_drop", 64'(tvalid), 64'd0);
    chk("t6_buf_level", 64'(buf_level), 64'd0);
    chk("t6_burst_cnt", 64'(burst_cnt), 64'd0);
    @(posedge clk); #1;
    rdy_mode = 0;
    send_rec(mkdata(900), 1, 50);
    drain("t6", 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
